// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between decode, the ALU issue stage and the ALU operation units.
// The slave modport is the issue stage's view; the master modport is the surrounding pipeline.
interface alu_issue_stage_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned FUNCT_W = 6
);
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 5;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [FUNCT_W-1:0]   in_funct;
    logic [SHAMT_W-1:0]   in_shamt;

    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_a;
    logic [WIDTH-1:0]     out_b;
    logic [OP_W-1:0]      out_op;
    logic [SHAMT_W-1:0]   out_shamt;
    logic                 out_illegal;

    modport master (
        output in_valid, in_a, in_b, in_funct, in_shamt, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_op, out_shamt, out_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_funct, in_shamt, out_ready,
        output in_ready, out_valid, out_a, out_b, out_op, out_shamt, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: decodes R-type funct and presents operands through a 2-entry skid buffer.
// Optional macro ALU_ISSUE_STATS_EN adds issue_count / stall_count output ports.
module alu_issue_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned FUNCT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    alu_issue_stage_if.slave    bus
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]         issue_count,
    output logic [31:0]         stall_count
`endif
);
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned CNT_W   = 32;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NOR  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ILL  = OP_W'(15);

    typedef struct packed {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [OP_W-1:0]    op;
        logic [SHAMT_W-1:0] shamt;
        logic               illegal;
    } entry_t;

    // Encoding is {skid_valid, main_valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t          state;
    entry_t          main_q;
    entry_t          skid_q;
    entry_t          in_entry;
    logic            in_ready_q;
    logic            main_valid;
    logic            accept;
    logic            consume;
    logic [OP_W-1:0] dec_op;
    logic            dec_illegal;

    // funct -> ALU op select; anything unrecognised is flagged illegal
    always_comb begin
        dec_op      = OP_ILL;
        dec_illegal = 1'b1;
        case (bus.in_funct)
            FUNCT_W'(6'h20), FUNCT_W'(6'h21): begin dec_op = OP_ADD;  dec_illegal = 1'b0; end
            FUNCT_W'(6'h22), FUNCT_W'(6'h23): begin dec_op = OP_SUB;  dec_illegal = 1'b0; end
            FUNCT_W'(6'h24):                  begin dec_op = OP_AND;  dec_illegal = 1'b0; end
            FUNCT_W'(6'h25):                  begin dec_op = OP_OR;   dec_illegal = 1'b0; end
            FUNCT_W'(6'h26):                  begin dec_op = OP_XOR;  dec_illegal = 1'b0; end
            FUNCT_W'(6'h27):                  begin dec_op = OP_NOR;  dec_illegal = 1'b0; end
            FUNCT_W'(6'h2A):                  begin dec_op = OP_SLT;  dec_illegal = 1'b0; end
            FUNCT_W'(6'h2B):                  begin dec_op = OP_SLTU; dec_illegal = 1'b0; end
            FUNCT_W'(6'h00):                  begin dec_op = OP_SLL;  dec_illegal = 1'b0; end
            FUNCT_W'(6'h02):                  begin dec_op = OP_SRL;  dec_illegal = 1'b0; end
            FUNCT_W'(6'h03):                  begin dec_op = OP_SRA;  dec_illegal = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        in_entry.a       = bus.in_a;
        in_entry.b       = bus.in_b;
        in_entry.op      = dec_op;
        in_entry.shamt   = bus.in_shamt;
        in_entry.illegal = dec_illegal;
    end

    assign main_valid = state[0];
    assign accept     = bus.in_valid && in_ready_q;
    assign consume    = main_valid && bus.out_ready;

    // Skid FSM; in_ready is registered and tracks "skid will be empty next cycle"
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= 1'b1;
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_entry;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_q <= in_entry;
                    end else if (accept) begin
                        skid_q     <= in_entry;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (consume) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = main_valid;
    assign bus.out_a       = main_q.a;
    assign bus.out_b       = main_q.b;
    assign bus.out_op      = main_q.op;
    assign bus.out_shamt   = main_q.shamt;
    assign bus.out_illegal = main_q.illegal;

`ifdef ALU_ISSUE_STATS_EN
    // Issue and backpressure statistics, free-running and wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (consume) begin
                issue_count <= issue_count + CNT_W'(1);
            end
            if (main_valid && !bus.out_ready) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected entries queued on accept, compared on consume.
module tb_alu_issue_stage;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned FUNCT_W = 6;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  shamt;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.WIDTH(WIDTH), .FUNCT_W(FUNCT_W)) bus ();

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] issue_count;
    logic [31:0] stall_count;
`endif

    alu_issue_stage #(.WIDTH(WIDTH), .FUNCT_W(FUNCT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .issue_count (issue_count),
        .stall_count (stall_count)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_out  = 0;
    bit   mon_en = 1'b0;
    logic m_rdy  = 1'b0;
    int unsigned m_issue = 0;
    int unsigned m_stall = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference funct decode, returns {illegal, op}
    function automatic logic [4:0] ref_dec(input logic [5:0] f);
        case (f)
            6'h20, 6'h21: return 5'h00;
            6'h22, 6'h23: return 5'h01;
            6'h24:        return 5'h02;
            6'h25:        return 5'h03;
            6'h26:        return 5'h04;
            6'h27:        return 5'h05;
            6'h2A:        return 5'h06;
            6'h2B:        return 5'h07;
            6'h00:        return 5'h08;
            6'h02:        return 5'h09;
            6'h03:        return 5'h0A;
            default:      return 5'h1F;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor at negedge: checks handshake against the model, then applies what the next edge will do
    always @(negedge clk) begin
        if (mon_en) begin
            logic       acc;
            logic       con;
            logic [4:0] d;
            exp_t       e;
            check("in_ready", 64'(bus.in_ready), 64'(m_rdy));
            check("out_valid", 64'(bus.out_valid), 64'(sb.size() > 0));
`ifdef ALU_ISSUE_STATS_EN
            check("issue_count", 64'(issue_count), 64'(m_issue));
            check("stall_count", 64'(stall_count), 64'(m_stall));
`endif
            acc = bus.in_valid && bus.in_ready;
            con = bus.out_valid && bus.out_ready;
            if (reset) begin
                sb.delete();
                m_rdy   = 1'b0;
                m_issue = 0;
                m_stall = 0;
            end else begin
                if (con) begin
                    if (sb.size() == 0) begin
                        check("underflow", 64'(1), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check("out_a", 64'(bus.out_a), 64'(e.a));
                        check("out_b", 64'(bus.out_b), 64'(e.b));
                        check("out_op", 64'(bus.out_op), 64'(e.op));
                        check("out_shamt", 64'(bus.out_shamt), 64'(e.shamt));
                        check("out_illegal", 64'(bus.out_illegal), 64'(e.illegal));
                        n_out++;
                    end
                    m_issue++;
                end
                if (bus.out_valid && !bus.out_ready) m_stall++;
                if (acc) begin
                    d = ref_dec(bus.in_funct);
                    e.a = bus.in_a;
                    e.b = bus.in_b;
                    e.op = d[3:0];
                    e.shamt = bus.in_shamt;
                    e.illegal = d[4];
                    sb.push_back(e);
                end
                m_rdy = (sb.size() < 2);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f, input logic [4:0] sh);
        logic hs;
        bit   done;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_funct = f;
        bus.in_shamt = sh;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
            if (hs) done = 1'b1;
        end
        if (!done) check("send_timeout", 64'(1), 64'(0));
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !bus.out_valid) done = 1'b1;
        end
        if (!done) check("idle_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] fl [14];
        bit         rnd_done;
        fl[0] = 6'h20; fl[1] = 6'h21; fl[2]  = 6'h22; fl[3]  = 6'h23; fl[4]  = 6'h24;
        fl[5] = 6'h25; fl[6] = 6'h26; fl[7]  = 6'h27; fl[8]  = 6'h2A; fl[9]  = 6'h2B;
        fl[10] = 6'h00; fl[11] = 6'h02; fl[12] = 6'h03; fl[13] = 6'h18;

        // Reset with in_valid held high
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'h1234_5678;
        bus.in_b      = 32'h9ABC_DEF0;
        bus.in_funct  = 6'h20;
        bus.in_shamt  = 5'd3;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_op", 64'(bus.out_op), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_out_a", 64'(bus.out_a), 64'(0));
        check("rst_out_illegal", 64'(bus.out_illegal), 64'(0));
        mon_en       = 1'b1;
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Single SLT transfer, one-cycle latency
        bus.out_ready = 1'b1;
        send(32'hFFFF_FFFE, 32'h0000_0003, 6'h2A, 5'd0);
        check("single_valid", 64'(bus.out_valid), 64'(1));
        check("single_op", 64'(bus.out_op), 64'(6));
        check("single_a", 64'(bus.out_a), 64'hFFFF_FFFE);
        check("single_b", 64'(bus.out_b), 64'h0000_0003);
        @(posedge clk);
        #1;
        check("single_drain", 64'(bus.out_valid), 64'(0));

        // Backpressure: third input waits until the skid drains
        bus.out_ready = 1'b0;
        fork
            begin
                send(32'd1, 32'd2, 6'h20, 5'd0);
                send(32'd3, 32'd4, 6'h22, 5'd0);
                send(32'd5, 32'd6, 6'h24, 5'd0);
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                check("bp_full_ready", 64'(bus.in_ready), 64'(0));
                check("bp_hold_op", 64'(bus.out_op), 64'(0));
                check("bp_hold_a", 64'(bus.out_a), 64'(1));
                bus.out_ready = 1'b1;
            end
        join
        wait_idle();

        // Streaming: accept and consume every cycle
        begin
            int c0;
            c0 = cyc;
            for (int i = 0; i < 8; i++) send(32'(i * 7), 32'(i + 100), fl[i], 5'(i));
            check("stream_cycles", 64'(cyc - c0), 64'(8));
        end
        wait_idle();

        // Illegal then legal SRA
        send(32'hDEAD_BEEF, 32'h8000_0000, 6'h18, 5'd0);
        check("ill_op", 64'(bus.out_op), 64'hF);
        check("ill_flag", 64'(bus.out_illegal), 64'(1));
        send(32'h0, 32'h8000_0000, 6'h03, 5'd7);
        check("sra_op", 64'(bus.out_op), 64'(10));
        check("sra_shamt", 64'(bus.out_shamt), 64'(7));
        check("sra_flag", 64'(bus.out_illegal), 64'(0));
        wait_idle();

        // Fill to FULL, then reset drops both entries
        bus.out_ready = 1'b0;
        send(32'hA, 32'hB, 6'h25, 5'd1);
        send(32'hC, 32'hD, 6'h26, 5'd2);
        check("full_ready", 64'(bus.in_ready), 64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_valid", 64'(bus.out_valid), 64'(0));
`ifdef ALU_ISSUE_STATS_EN
        check("midrst_issue", 64'(issue_count), 64'(0));
        check("midrst_stall", 64'(stall_count), 64'(0));
`endif
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_stale", 64'(bus.out_valid), 64'(0));

        // Random traffic with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [5:0] f;
                    f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fl[$urandom_range(0, 13)];
                    send($urandom, $urandom, f, 5'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_idle();
        check("drained", 64'(sb.size()), 64'(0));
        check("total_out", 64'(n_out), 64'(1 + 3 + 8 + 2 + 150));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered issue stage directly upstream of the ALU operation units (slt, add/sub, logic, shifts).
- Accepts operands plus the R-type funct/shamt fields from decode over a valid/ready handshake and decodes funct into a 4-bit ALU op select.
- Presents registered operands and op to the ALU through a 2-entry skid buffer, so all outputs are register-driven and backpressure never creates a combinational ready path.

Parameters:
- WIDTH, 32, operand width in bits.
- FUNCT_W, 6, width of the funct field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a valid instruction.
- in_ready  out  1  stage can accept; registered, equals NOT skid_valid.
- in_a  in  WIDTH  operand A (rs).
- in_b  in  WIDTH  operand B (rt).
- in_funct  in  FUNCT_W  R-type funct field.
- in_shamt  in  5  shift amount.
- out_valid  out  1  ALU inputs are valid.
- out_ready  in  1  ALU/downstream accepts.
- out_a  out  WIDTH  registered operand A.
- out_b  out  WIDTH  registered operand B.
- out_op  out  4  decoded ALU op select.
- out_shamt  out  5  registered shamt.
- out_illegal  out  1  funct not supported; out_op = 4'hF.

Behaviour:
- Reset: out_valid=0, in_ready=0 during reset, in_ready=1 the first cycle after reset; out_a/out_b=0, out_op=0, out_shamt=0, out_illegal=0; skid entry cleared.
- Transfer rules: in accepted when in_valid && in_ready at the edge; out consumed when out_valid && out_ready at the edge.
- Decode is combinational on in_funct and registered with the entry:
  - 0x20 or 0x21 -> 0 ADD.
  - 0x22 or 0x23 -> 1 SUB.
  - 0x24 -> 2 AND.
  - 0x25 -> 3 OR.
  - 0x26 -> 4 XOR.
  - 0x27 -> 5 NOR.
  - 0x2A -> 6 SLT (signed).
  - 0x2B -> 7 SLTU.
  - 0x00 -> 8 SLL.
  - 0x02 -> 9 SRL.
  - 0x03 -> 10 SRA.
  - Any other value -> op 4'hF and illegal=1.
- Operands pass unmodified; no sign or zero extension is done here.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00): accept -> ONE, with the entry loaded into main.
  - ONE (01):
    - out consumed with no accept -> EMPTY.
    - Accept and consume in the same cycle -> ONE, main reloaded with the new entry.
    - Accept with no consume -> FULL, new entry goes to skid.
  - FULL (11): in_ready=0. On consume, skid moves to main -> ONE. New input is ignored (in_ready already 0).
- Latency: an accepted entry appears on out_* at the next rising edge (1 cycle).
- Ordering is strictly FIFO. Maximum 2 entries in flight.
- out_* stay stable while out_valid && !out_ready. Outputs change only on consume or when filling from EMPTY.
- Reset mid-operation drops all entries in the same edge. No partial output.
- in_valid while in_ready=0 has no effect. Upstream must hold its data.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- When defined, two extra output ports are added:
  - issue_count (32): increments on every out consume.
  - stall_count (32): increments every cycle where out_valid && !out_ready.
- Both counters reset to 0 and wrap modulo 2^32. Illegal entries are counted in issue_count like any other entry.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset with in_valid=1 -> out_valid=0, out_op=0 during reset; in_ready=1 one cycle after reset deasserts.
- Single transfer: in_a=0xFFFFFFFE, in_b=0x00000003, funct=0x2A, out_ready=1 -> next cycle out_valid=1, out_op=6, out_a/out_b unchanged; out_valid=0 the cycle after.
- Backpressure: out_ready=0, three back-to-back valid inputs (funct 0x20, 0x22, 0x24) -> accepts the first two, in_ready=0 after the second; on releasing out_ready, ops 0,1,2 come out in order; the third is accepted only after in_ready returns to 1.
- Simultaneous accept and consume in ONE state for 8 cycles with out_ready=1 -> one output per cycle, in_ready stays 1, no skid use.
- Illegal funct 0x18 -> out_op=0xF, out_illegal=1; the next legal funct 0x03 with shamt=7 -> out_op=10, out_shamt=7, out_illegal=0.
- FULL state then reset asserted for one cycle -> out_valid=0 after the edge, no stale entry emitted; with ALU_ISSUE_STATS_EN both counters read 0.
